// File: rtl/alu_sched_pkg.sv
// Shared constants for the ALU round-robin scheduler: opcodes, FSM encoding and data width.
package alu_sched_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] OP_NOT = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_NEG = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from last_grant+1,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int unsigned k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        // i == NUM_REQ revisits last_grant itself, so a lone requester can be re-granted
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            k = (32'(last_grant) + i) % NUM_REQ;
            if (!any && req[k]) begin
                grant[k] = 1'b1;
                idx      = ID_W'(k);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external 32-bit ALU between NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Optional ALU_RR_GRANT_CNT_EN adds per-requester 16-bit saturating grant counters.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [DATA_W*NUM_REQ-1:0]   req_a,
    input  logic [DATA_W*NUM_REQ-1:0]   req_b,
    input  logic [3*NUM_REQ-1:0]        req_sel,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    output logic [2:0]                  alu_sel,
    input  logic [DATA_W-1:0]           alu_out,
    input  logic                        alu_c,
    input  logic                        alu_z,
    input  logic                        alu_n,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [ID_W-1:0]             resp_id,
    output logic [DATA_W-1:0]           resp_out,
    output logic                        resp_c,
    output logic                        resp_z,
    output logic                        resp_n,
    output logic                        resp_err
`ifdef ALU_RR_GRANT_CNT_EN
    ,
    output logic [16*NUM_REQ-1:0]       grant_cnt
`endif
);

    logic [1:0]         state;
    logic [ID_W-1:0]    last_grant;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .idx        (grant_idx),
        .any        (grant_any)
    );

    // Grant is only visible in IDLE and never while reset is held
    assign accept    = (state == IDLE) && grant_any && !rst;
    assign req_ready = accept ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_out   <= '0;
            resp_c     <= 1'b0;
            resp_z     <= 1'b0;
            resp_n     <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_a      <= req_a[DATA_W*32'(grant_idx) +: DATA_W];
                        alu_b      <= req_b[DATA_W*32'(grant_idx) +: DATA_W];
                        alu_sel    <= req_sel[3*32'(grant_idx) +: 3];
                        last_grant <= grant_idx;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_out   <= alu_out;
                    resp_c     <= alu_c;
                    resp_z     <= alu_z;
                    resp_n     <= alu_n;
                    resp_id    <= last_grant;
                    resp_err   <= (alu_sel == OP_DIV) && (alu_b == '0);
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_RR_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (accept) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (grant[i] && grant_cnt[16*i +: 16] != 16'hFFFF) begin
                    grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a behavioural ALU and a response scoreboard.
module tb_alu_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [3*NUM_REQ-1:0] req_sel;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [2:0]           alu_sel;
    logic [31:0]          alu_out;
    logic                 alu_c;
    logic                 alu_z;
    logic                 alu_n;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [ID_W-1:0]      resp_id;
    logic [31:0]          resp_out;
    logic                 resp_c;
    logic                 resp_z;
    logic                 resp_n;
    logic                 resp_err;
`ifdef ALU_RR_GRANT_CNT_EN
    logic [16*NUM_REQ-1:0] grant_cnt;
`endif

    alu_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_c      (alu_c),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_out   (resp_out),
        .resp_c     (resp_c),
        .resp_z     (resp_z),
        .resp_n     (resp_n),
        .resp_err   (resp_err)
`ifdef ALU_RR_GRANT_CNT_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external shared ALU
    logic [32:0] add_t;
    always_comb begin
        add_t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = 1'b0;
        case (alu_sel)
            3'd0: alu_out = ~alu_a;
            3'd1: alu_out = alu_a | alu_b;
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = -alu_a;
            3'd4: begin alu_out = add_t[31:0]; alu_c = add_t[32]; end
            3'd5: begin alu_out = alu_a - alu_b; alu_c = (alu_a < alu_b); end
            3'd6: alu_out = alu_a * alu_b;
            default: alu_out = (alu_b == 32'd0) ? 32'd0 : alu_a / alu_b;
        endcase
        alu_z = (alu_out == 32'd0);
        alu_n = alu_out[31];
    end

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] out;
        logic        c;
        logic        z;
        logic        n;
        logic        err;
    } resp_t;

    resp_t sbq[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] out, input logic c, input logic z,
                        input logic n, input logic err);
        resp_t e;
        e.id = 2'(id); e.out = out; e.c = c; e.z = z; e.n = n; e.err = err;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge after the accept edge.
    task automatic send(input string tag, input int id, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] sel);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_sel[3*id +: 3] = sel;
        req_valid[id] = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(1) << id);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic cmp_resp(input string tag);
        resp_t e;
        total++;
        assert (sbq.size() > 0) else begin
            bad++;
            $error("FAIL %s_unexpected observed=resp id %0d expected=none", tag, resp_id);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_id"},  32'(resp_id),  32'(e.id));
            chk({tag, "_out"}, resp_out,      e.out);
            chk({tag, "_c"},   32'(resp_c),   32'(e.c));
            chk({tag, "_z"},   32'(resp_z),   32'(e.z));
            chk({tag, "_n"},   32'(resp_n),   32'(e.n));
            chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
        end
    endtask

    task automatic get_resp(input string tag);
        int n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        if (resp_valid === 1'b1) cmp_resp(tag);
        @(negedge clk);
    endtask

    initial begin
        int exp_order[5];
        int g;
        int last_cyc;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; resp_ready = 1'b1;
        do_reset();

        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        chk("rst_resp_out",   resp_out,        32'd0);
        chk("rst_alu_a",      alu_a,           32'd0);
        chk("rst_alu_sel",    32'(alu_sel),    32'd0);

        // Single request with latency check
        push(2, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        send("t1", 2, 32'd5, 32'd7, 3'd4);
        chk("t1_lat_exec", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("t1_lat_resp", 32'(resp_valid), 32'd1);
        get_resp("t1");

        // Round robin from fresh reset: 0,1,2,3,0 at 3-cycle spacing
        do_reset();
        exp_order = '{0, 1, 2, 3, 0};
        req_a = {32'd4, 32'd3, 32'd2, 32'd1};
        req_b = {32'd10, 32'd10, 32'd10, 32'd10};
        req_sel = {3'd4, 3'd4, 3'd4, 3'd4};
        req_valid = '1;
        g = 0;
        last_cyc = -1;
        for (int cyc = 0; cyc < 40 && g < 5; cyc++) begin
            #1;
            if (req_ready != '0) begin
                chk("rr_grant", 32'(req_ready), 32'(1) << exp_order[g]);
                if (g > 0) chk("rr_interval", 32'(cyc - last_cyc), 32'd3);
                push(exp_order[g], 32'(exp_order[g] + 11), 1'b0, 1'b0, 1'b0, 1'b0);
                last_cyc = cyc;
                g++;
            end
            if (resp_valid === 1'b1) cmp_resp("rr");
            @(negedge clk);
        end
        chk("rr_count", 32'(g), 32'd5);
        req_valid = '0;
        get_resp("rr_last");

        // Divide, including divide-by-zero
        push(1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        send("div0", 1, 32'd100, 32'd0, 3'd7);
        get_resp("div0");
        push(1, 32'd14, 1'b0, 1'b0, 1'b0, 1'b0);
        send("div7", 1, 32'd100, 32'd7, 3'd7);
        get_resp("div7");

        // Borrow / negative
        push(3, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0);
        send("sub", 3, 32'd3, 32'd5, 3'd5);
        get_resp("sub");
        push(0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        send("not", 0, 32'd0, 32'd0, 3'd0);
        get_resp("not");

        // Backpressure: response held, no grant until the cycle after the handshake
        resp_ready = 1'b0;
        push(1, 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);
        send("bp", 1, 32'd20, 32'd22, 3'd4);
        @(negedge clk);
        req_a[31:0] = 32'd1; req_b[31:0] = 32'd1; req_sel[2:0] = 3'd4;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_out",   resp_out,        32'd42);
            chk("bp_id",    32'(resp_id),    32'd1);
            chk("bp_ready", 32'(req_ready),  32'd0);
            @(negedge clk);
        end
        cmp_resp("bp");
        resp_ready = 1'b1;
        #1;
        chk("bp_hs_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("bp_after_valid", 32'(resp_valid), 32'd0);
        chk("bp_after_grant", 32'(req_ready),  32'd1);
        push(0, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = '0;
        get_resp("bp2");

        // Reset during EXEC discards the op and restarts arbitration from requester 0
        send("mid", 2, 32'd1, 32'd1, 3'd4);
        rst = 1'b1;
        req_a[31:0] = 32'd9;   req_b[31:0] = 32'd3;   req_sel[2:0] = 3'd6;
        req_a[127:96] = 32'd8; req_b[127:96] = 32'd8; req_sel[11:9] = 3'd4;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("mid_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_resp_out",   resp_out,        32'd0);
        chk("mid_resp_err",   32'(resp_err),   32'd0);
        chk("mid_alu_a",      alu_a,           32'd0);
        rst = 1'b0;
        #1;
        chk("mid_first_grant", 32'(req_ready), 32'd1);
        push(0, 32'd27, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = '0;
        get_resp("mid");
        for (int i = 0; i < 4; i++) begin
            chk("mid_no_extra", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Round-robin scheduler that shares one 32-bit combinational ALU between NUM_REQ requesters. Each requester presents operands and a 3-bit opcode with a valid/ready handshake. The scheduler registers the winning operation, drives the shared ALU ports, captures its result and flags, and returns them on a single response channel tagged with the requester ID. It sits between the issuing units and the ALU instance; the ALU itself stays outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width; must equal clog2(NUM_REQ)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
req_a  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i]
req_b  in  32*NUM_REQ  operand B, packed the same way
req_sel  in  3*NUM_REQ  ALU opcode, packed [3i+2:3i]
alu_a  out  32  operand A to the shared ALU
alu_b  out  32  operand B to the shared ALU
alu_sel  out  3  opcode to the shared ALU
alu_out  in  32  ALU result
alu_c, alu_z, alu_n  in  1 each  ALU carry/borrow, zero and negative flags
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_id  out  ID_W  requester that issued the operation
resp_out  out  32  captured result
resp_c, resp_z, resp_n  out  1 each  captured flags
resp_err  out  1  set for divide (sel=3'b111) with b==0

Behaviour:
- FSM with three states: IDLE, EXEC, RESP. Reset puts it in IDLE. Reset also clears to zero req_ready, resp_valid, resp_id, resp_out, resp_c/z/n, resp_err, alu_a, alu_b and alu_sel, and sets last_grant to NUM_REQ-1.
- IDLE: if any req_valid is high, pick the first set bit searching from last_grant+1 upward, with modulo NUM_REQ wrap. Assert req_ready[k] combinationally in this cycle; the transfer completes on this edge. Latch req_a/b/sel of k into alu_a/alu_b/alu_sel registers, set last_grant=k, go to EXEC. With no valid requests, stay in IDLE.
- req_ready is zero in EXEC and RESP; no request is accepted while an operation is in flight.
- EXEC (one cycle): the ALU settles combinationally from the registered inputs. On the edge, capture alu_out/c/z/n into the resp_* registers, set resp_id=k, set resp_err=(alu_sel==3'b111 && alu_b==0), set resp_valid=1, go to RESP.
- RESP: hold all resp_* stable while resp_valid=1 && resp_ready=0. On resp_valid && resp_ready, clear resp_valid and go to IDLE. The next grant comes at the earliest in the following cycle.
- Latency: from accept edge to resp_valid high is 2 cycles. Minimum issue interval is 3 cycles.
- alu_a/b/sel hold their last values outside EXEC; they do not return to zero.
- Fairness: a requester that keeps req_valid high is served within NUM_REQ grants.
- Requesters may drop req_valid without a grant. Only the current-cycle valids are considered.
- Reset asserted in any state: the in-flight operation is discarded with no response, and the FSM restarts in IDLE next cycle.
- resp_err is informational; resp_out is still whatever the ALU produced (0 for divide-by-zero).

Optional Feature:
ALU_RR_GRANT_CNT_EN
- Defined: adds output grant_cnt (16*NUM_REQ). It holds one 16-bit saturating counter per requester, incremented on each accepted request, cleared by rst, and stuck at 16'hFFFF once reached.
- Undefined: the port and the counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_sched_pkg: opcode localparams (OP_NOT=0, OP_OR=1, OP_AND=2, OP_NEG=3, OP_ADD=4, OP_SUB=5, OP_MUL=6, OP_DIV=7), the FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), and the 32-bit data width constant.
- Sub-module rr_arbiter: a combinational round-robin picker. Inputs are the request vector and last_grant; outputs are a one-hot grant, an index and an any flag. It is reusable by other shared-resource blocks.

Test Plan:
1. Single request: after reset, req 2 sends a=5, b=7, sel=4 -> req_ready[2] high in the request cycle; 2 cycles later resp_valid=1, resp_id=2, resp_out=12, c=0, z=0, n=0.
2. Round-robin: all 4 valid continuously, resp_ready=1 -> grant order 0,1,2,3,0 with one grant every 3 cycles; last_grant wraps correctly.
3. Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_* stable, req_ready all zero, and no new grant until the cycle after the handshake.
4. Divide-by-zero: a=100, b=0, sel=7 -> resp_out=0, resp_z=1, resp_err=1. Then a=100, b=7, sel=7 -> resp_out=14, resp_err=0.
5. Borrow/negative: sel=5, a=3, b=5 -> resp_out=32'hFFFFFFFE, resp_c=1, resp_n=1. Then sel=0, a=0 -> resp_out=32'hFFFFFFFF, resp_n=1.
6. Mid-op reset: assert rst during EXEC -> no resp_valid afterwards, all outputs at reset values, and the next request from req 0 is granted first.
